maxnet: RTL and testbench

//   Four-input MAXNET winner-take-all network for the CA2 datapath.
//   On start it loads X1..X4 as fixed-point activations and iterates

---
 rtl/maxnet_pkg.sv | 18 +
 rtl/maxnet_pe.sv | 27 ++
 rtl/maxnet.sv | 114 +++++++++++
 tb/tb_maxnet.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and default sizing for the four-input MAXNET winner-take-all block.
package maxnet_pkg;

  localparam int N_IN          = 4;
  localparam int DEF_DATA_W    = 5;
  localparam int DEF_FRAC_W    = 8;
  localparam int DEF_EPS_SHIFT = 3;
  localparam int DEF_ACC_W     = DEF_DATA_W + DEF_FRAC_W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    LOAD,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/maxnet_pe.sv
// One MAXNET neuron: applies lateral inhibition from the other three activations.
module maxnet_pe #(
  parameter int ACC_W     = 13,
  parameter int EPS_SHIFT = 3
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W+1:0] sum,
  output logic [ACC_W-1:0] a_next,
  output logic             nonzero,
  output logic             changed
);

  localparam int SUM_W = ACC_W + 2;

  logic [SUM_W-1:0] others;
  logic [SUM_W-1:0] inh;

  // Inhibition is an eps-weighted sum of the other neurons; the neuron clamps at zero.
  always_comb begin
    others  = sum - SUM_W'(a);
    inh     = others >> EPS_SHIFT;
    a_next  = (SUM_W'(a) > inh) ? ACC_W'(SUM_W'(a) - inh) : '0;
    nonzero = (a_next != '0);
    changed = (a_next != a);
  end

endmodule

// File: rtl/maxnet.sv
// Four-input MAXNET: iterates lateral inhibition until one neuron survives or the
// network stalls, then reports the winner's original input value.
module maxnet
  import maxnet_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int EPS_SHIFT = DEF_EPS_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] X1,
  input  logic [DATA_W-1:0] X2,
  input  logic [DATA_W-1:0] X3,
  input  logic [DATA_W-1:0] X4,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int ACC_W = DATA_W + FRAC_W;
  localparam int SUM_W = ACC_W + 2;

  state_t state_q, state_d;

  logic [DATA_W-1:0] x      [N_IN];
  logic [DATA_W-1:0] orig   [N_IN];
  logic [ACC_W-1:0]  act    [N_IN];
  logic [ACC_W-1:0]  a_next [N_IN];
  logic [N_IN-1:0]   nonzero;
  logic [N_IN-1:0]   changed;
  logic [SUM_W-1:0]  sum;
  logic [2:0]        nz_cnt;
  logic              terminate;
  logic [DATA_W-1:0] win_val;

  assign x[0] = X1;
  assign x[1] = X2;
  assign x[2] = X3;
  assign x[3] = X4;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + SUM_W'(act[i]);
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_pe
    maxnet_pe #(
      .ACC_W    (ACC_W),
      .EPS_SHIFT(EPS_SHIFT)
    ) u_pe (
      .a      (act[g]),
      .sum    (sum),
      .a_next (a_next[g]),
      .nonzero(nonzero[g]),
      .changed(changed[g])
    );
  end

  // Stop on a single survivor or when no activation moved (ties); lowest index wins.
  always_comb begin
    nz_cnt  = '0;
    win_val = '0;
    for (int i = 0; i < N_IN; i++) nz_cnt = nz_cnt + {2'b00, nonzero[i]};
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (nonzero[i]) win_val = orig[i];
    end
    terminate = (nz_cnt <= 3'd1) || (changed == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)     state_d = WAIT_LOW;
      WAIT_LOW: if (!start)    state_d = LOAD;
      LOAD:                    state_d = ITER;
      ITER:     if (terminate) state_d = DONE;
      DONE:     if (start)     state_d = WAIT_LOW;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      for (int i = 0; i < N_IN; i++) begin
        act[i]  <= '0;
        orig[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          for (int i = 0; i < N_IN; i++) begin
            act[i]  <= {x[i], {FRAC_W{1'b0}}};
            orig[i] <= x[i];
          end
        end
        ITER: begin
          for (int i = 0; i < N_IN; i++) act[i] <= a_next[i];
          if (terminate) result <= win_val;
        end
        default: ;
      endcase
    end
  end

  assign done = (state_q == DONE);

endmodule

// File: tb/tb_maxnet.sv
// Self-checking bench for maxnet: directed cases plus randomized runs against an
// integer-arithmetic model of winner-take-all inhibition.
module tb_maxnet;

  localparam int DW   = 5;
  localparam int FRAC = 8;
  localparam int EPS  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] X1, X2, X3, X4;
  logic          done;
  logic [DW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  maxnet dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X1    (X1),
    .X2    (X2),
    .X3    (X3),
    .X4    (X4),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: activations in units of 2^-FRAC, eps realised as integer division.
  function automatic void model(input int v[4], output int res, output int iters);
    int a[4];
    int nxt[4];
    int s, inh, live;
    bit moved;
    for (int i = 0; i < 4; i++) a[i] = v[i] * (2 ** FRAC);
    iters = 0;
    do begin
      iters++;
      s = a[0] + a[1] + a[2] + a[3];
      live  = 0;
      moved = 0;
      for (int i = 0; i < 4; i++) begin
        inh    = (s - a[i]) / (2 ** EPS);
        nxt[i] = (a[i] > inh) ? a[i] - inh : 0;
        if (nxt[i] != 0) live++;
        if (nxt[i] != a[i]) moved = 1;
      end
      a = nxt;
    end while (live > 1 && moved && iters < 10000);
    res = 0;
    for (int i = 3; i >= 0; i--) if (a[i] != 0) res = v[i];
  endfunction

  // exp_res < 0 means take the expected result from the model.
  task automatic apply_stimulus(input int v0, input int v1, input int v2, input int v3,
                                input int exp_res, input int hold, input bit noise,
                                input string tag);
    int v[4];
    int m_res, m_it, cycles, exp_val;
    logic [DW-1:0] prev;
    bit held;
    v = '{v0, v1, v2, v3};
    model(v, m_res, m_it);
    exp_val = (exp_res < 0) ? m_res : exp_res;
    @(negedge clk);
    X1 = DW'(v0); X2 = DW'(v1); X3 = DW'(v2); X4 = DW'(v3);
    start = 1'b1;
    prev  = result;
    repeat (hold) @(negedge clk);
    check_output({tag, "/done_low"}, {31'd0, done}, 32'd0);
    start  = 1'b0;
    cycles = 0;
    held   = 1'b1;
    while (done !== 1'b1 && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (done !== 1'b1 && result !== prev) held = 1'b0;
      if (noise && cycles == 2) begin
        X1 = DW'($urandom); X2 = DW'($urandom); X3 = DW'($urandom); X4 = DW'($urandom);
        start = 1'b1;
      end
      if (noise && cycles == 3) start = 1'b0;
    end
    check_output({tag, "/done"}, {31'd0, done}, 32'd1);
    check_output({tag, "/latency"}, cycles, 2 + m_it);
    check_output({tag, "/result"}, {27'd0, result}, exp_val);
    check_output({tag, "/result_held"}, {31'd0, held}, 32'd1);
    repeat (2) @(negedge clk);
    check_output({tag, "/done_stays"}, {31'd0, done}, 32'd1);
    check_output({tag, "/result_stays"}, {27'd0, result}, exp_val);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    X1 = '0; X2 = '0; X3 = '0; X4 = '0;
    #12;
    check_output("reset/done", {31'd0, done}, 32'd0);
    check_output("reset/result", {27'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    apply_stimulus(1, 2, 3, 4, 4, 1, 1'b0, "c1234");
    apply_stimulus(7, 2, 1, 4, 7, 1, 1'b0, "c7214");
    apply_stimulus(3, 6, 7, 4, 7, 1, 1'b1, "c3674");
    apply_stimulus(7, 5, 5, 4, 7, 2, 1'b0, "c7554");
    apply_stimulus(5, 5, 2, 1, 5, 1, 1'b0, "tie5521");
    apply_stimulus(0, 0, 0, 0, 0, 1, 1'b0, "zeros");
    apply_stimulus(31, 0, 0, 30, -1, 3, 1'b1, "hold3");

    // Abort a run in the middle of iterating.
    @(negedge clk);
    X1 = 5'd1; X2 = 5'd2; X3 = 5'd3; X4 = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midrun/done", {31'd0, done}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_output("midrun_reset/done", {31'd0, done}, 32'd0);
    check_output("midrun_reset/result", {27'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1, 2, 3, 4, 4, 1, 1'b0, "rerun");

    for (int n = 0; n < 8; n++) begin
      apply_stimulus($urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     -1, $urandom_range(1, 3), 1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
